boolean1_sweep_ctrl: RTL

//  Truth-table sweep controller for the 3-input boolean datapath d = (~a|~b)&~c.
//  On start it drives all 8 input vectors onto the datapath, waits a settle time,

---
 rtl/boolean1_sweep_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/boolean1_sweep_ctrl.sv
// boolean1_sweep_ctrl
//   Truth-table sweep controller for the 3-input datapath d = (~a|~b)&~c.
//   On an accepted start it walks all eight {a,b,c} vectors. Each vector is
//   held for max(SETTLE_CYCLES,1) cycles, then d is captured into result[idx].
//   At the end of the sweep the result is compared with EXPECTED.
//   Optional feature macro: BOOL_SWEEP_ERRCNT_EN adds a 4-bit mismatch counter
//   output, err_cnt.
module boolean1_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] EXPECTED      = 8'h15,
  parameter int         CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       d_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass
`ifdef BOOL_SWEEP_ERRCNT_EN
  ,
  output logic [3:0] err_cnt
`endif
);

  // A settle time of 0 is treated as 1 so that every vector is driven for at
  // least one cycle before it is sampled.
  localparam int               S_EFF    = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_EFF - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [2:0]       idx;
  logic [2:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       result_nxt;

  assign {a_o, b_o, c_o} = vec;

  // Result with the current sample merged in. pass is computed from this value
  // so that it is already valid in the DONE cycle.
  always_comb begin
    result_nxt      = result;
    result_nxt[idx] = d_i;
  end

`ifdef BOOL_SWEEP_ERRCNT_EN
  logic miss;
  assign miss = (d_i != EXPECTED[idx]);

  // Mismatch counter: cleared on an accepted start, stepped once per SAMPLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 4'd0;
    end else if (state == IDLE && start) begin
      err_cnt <= 4'd0;
    end else if (state == SAMPLE) begin
      err_cnt <= err_cnt + {3'd0, miss};
    end
  end
`endif

  // Sweep FSM: drives the vector, times the settle window and captures d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 3'd0;
      vec    <= 3'd0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 8'h00;
      pass   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= 3'd0;
            vec    <= 3'd0;
            cnt    <= '0;
            result <= 8'h00;
            pass   <= 1'b0;
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          result <= result_nxt;
          if (idx == 3'd7) begin
            pass  <= (result_nxt == EXPECTED);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            vec   <= idx + 3'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          vec   <= 3'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
